// File: rtl/ahbl_arb_if.sv
// Signal bundle around the two-requester AHB-Lite arbiter: both requester ports plus the
// shared address/data/response port towards the AHB-to-APB bridge.
interface ahbl_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic              m0_req;
  logic              m0_gnt;
  logic [ADDR_W-1:0] m0_haddr;
  logic [1:0]        m0_htrans;
  logic [2:0]        m0_hsize;
  logic [2:0]        m0_hburst;
  logic [3:0]        m0_hprot;
  logic              m0_hwrite;
  logic [DATA_W-1:0] m0_hwdata;
  logic [DATA_W-1:0] m0_hrdata;
  logic              m0_hready;
  logic              m0_hresp;

  logic              m1_req;
  logic              m1_gnt;
  logic [ADDR_W-1:0] m1_haddr;
  logic [1:0]        m1_htrans;
  logic [2:0]        m1_hsize;
  logic [2:0]        m1_hburst;
  logic [3:0]        m1_hprot;
  logic              m1_hwrite;
  logic [DATA_W-1:0] m1_hwdata;
  logic [DATA_W-1:0] m1_hrdata;
  logic              m1_hready;
  logic              m1_hresp;

  logic              hsel;
  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic [3:0]        hprot;
  logic              hwrite;
  logic [DATA_W-1:0] hwdata;
  logic [DATA_W-1:0] hrdata;
  logic              hready;
  logic              hresp;

  // Handshake: a requester raises mN_req and holds it while it has work; mN_gnt marks
  // address-phase ownership, and a beat is accepted on an edge where mN_gnt, htrans[1] and hready are all 1.

  // Arbiter view: requester address phases and the slave response come in, grants and the shared bus go out.
  modport slave (
    input  m0_req, m0_haddr, m0_htrans, m0_hsize, m0_hburst, m0_hprot, m0_hwrite, m0_hwdata,
    output m0_gnt, m0_hrdata, m0_hready, m0_hresp,
    input  m1_req, m1_haddr, m1_htrans, m1_hsize, m1_hburst, m1_hprot, m1_hwrite, m1_hwdata,
    output m1_gnt, m1_hrdata, m1_hready, m1_hresp,
    output hsel, haddr, htrans, hsize, hburst, hprot, hwrite, hwdata,
    input  hrdata, hready, hresp
  );

  // Environment view: the two upstream masters and the downstream slave.
  modport master (
    output m0_req, m0_haddr, m0_htrans, m0_hsize, m0_hburst, m0_hprot, m0_hwrite, m0_hwdata,
    input  m0_gnt, m0_hrdata, m0_hready, m0_hresp,
    output m1_req, m1_haddr, m1_htrans, m1_hsize, m1_hburst, m1_hprot, m1_hwrite, m1_hwdata,
    input  m1_gnt, m1_hrdata, m1_hready, m1_hresp,
    input  hsel, haddr, htrans, hsize, hburst, hprot, hwrite, hwdata,
    output hrdata, hready, hresp
  );
endinterface

// File: rtl/ahbl_arb.sv
// Two-requester AHB-Lite arbiter/mux: round-robin ownership at transfer boundaries,
// address mux by owner, write-data mux and error routing by data-phase owner.
module ahbl_arb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic       hclk,
  input  logic       hresetn,
  ahbl_arb_if.slave  bus,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       last_q, last_d;
  logic       used_q, used_d;
  logic       dph_vld_q;
  logic       dph_own_q;
  logic       own_req;
  logic       handover;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      used_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      used_q  <= used_d;
    end
  end

  // Address-phase mux: zero latency, everything forced to 0 when nobody owns the bus.
  always_comb begin
    bus.hsel   = 1'b0;
    bus.haddr  = {ADDR_W{1'b0}};
    bus.htrans = 2'b00;
    bus.hsize  = 3'b000;
    bus.hburst = 3'b000;
    bus.hprot  = 4'b0000;
    bus.hwrite = 1'b0;
    own_req    = 1'b0;
    case (state_q)
      OWN0: begin
        bus.hsel   = 1'b1;
        bus.haddr  = bus.m0_haddr;
        bus.htrans = bus.m0_htrans;
        bus.hsize  = bus.m0_hsize;
        bus.hburst = bus.m0_hburst;
        bus.hprot  = bus.m0_hprot;
        bus.hwrite = bus.m0_hwrite;
        own_req    = bus.m0_req;
      end
      OWN1: begin
        bus.hsel   = 1'b1;
        bus.haddr  = bus.m1_haddr;
        bus.htrans = bus.m1_htrans;
        bus.hsize  = bus.m1_hsize;
        bus.hburst = bus.m1_hburst;
        bus.hprot  = bus.m1_hprot;
        bus.hwrite = bus.m1_hwrite;
        own_req    = bus.m1_req;
      end
      default: ;
    endcase
  end

  // Only an IDLE beat may end a tenure, so SEQ/BUSY keep a burst together.
  assign handover = bus.hready && (bus.htrans == 2'b00) && (used_q || !own_req);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    used_d  = used_q;
    if (bus.hready) begin
      case (state_q)
        IDLE: begin
          if (bus.m0_req && bus.m1_req) state_d = last_q ? OWN0 : OWN1;
          else if (bus.m0_req)          state_d = OWN0;
          else if (bus.m1_req)          state_d = OWN1;
        end
        OWN0: begin
          if (handover) begin
            if (bus.m1_req)      state_d = OWN1;
            else if (bus.m0_req) state_d = OWN0;
            else                 state_d = IDLE;
          end
        end
        OWN1: begin
          if (handover) begin
            if (bus.m0_req)      state_d = OWN0;
            else if (bus.m1_req) state_d = OWN1;
            else                 state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
      if (state_d != state_q)        used_d = 1'b0;
      else if (bus.htrans == 2'b10)  used_d = 1'b1;
      if (state_d == OWN0)      last_d = 1'b0;
      else if (state_d == OWN1) last_d = 1'b1;
    end
  end

  // Data-phase owner trails the address phase by one accepted beat.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      dph_vld_q <= 1'b0;
      dph_own_q <= 1'b0;
    end else if (bus.hready) begin
      dph_vld_q <= bus.htrans[1];
      if (bus.htrans[1]) dph_own_q <= (state_q == OWN1);
    end
  end

  assign bus.hwdata    = !dph_vld_q ? {DATA_W{1'b0}} : (dph_own_q ? bus.m1_hwdata : bus.m0_hwdata);
  assign bus.m0_gnt    = (state_q == OWN0);
  assign bus.m1_gnt    = (state_q == OWN1);
  assign bus.m0_hresp  = bus.hresp & dph_vld_q & !dph_own_q;
  assign bus.m1_hresp  = bus.hresp & dph_vld_q & dph_own_q;
  assign bus.m0_hrdata = bus.hrdata;
  assign bus.m1_hrdata = bus.hrdata;
  assign bus.m0_hready = bus.hready;
  assign bus.m1_hready = bus.hready;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_ahbl_arb.sv
// Bench for ahbl_arb: directed scenarios plus random traffic, every cycle's outputs
// checked against a reference model through an expected-value queue.
module tb_ahbl_arb;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int EW = 148;

  logic       hclk = 1'b0;
  logic       hresetn;
  logic [1:0] dbg_state;

  always #5 hclk = ~hclk;

  ahbl_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  ahbl_arb #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .hclk(hclk), .hresetn(hresetn), .bus(bus), .dbg_state(dbg_state)
  );

  // Stimulus registers per requester and for the downstream slave.
  logic        a_req[2];
  logic [31:0] a_addr[2];
  logic [1:0]  a_trans[2];
  logic [2:0]  a_size[2];
  logic [2:0]  a_burst[2];
  logic [3:0]  a_prot[2];
  logic        a_wr[2];
  logic [31:0] a_wdata[2];
  logic        s_ready, s_resp;
  logic [31:0] s_rdata;

  assign bus.m0_req = a_req[0];   assign bus.m1_req = a_req[1];
  assign bus.m0_haddr = a_addr[0]; assign bus.m1_haddr = a_addr[1];
  assign bus.m0_htrans = a_trans[0]; assign bus.m1_htrans = a_trans[1];
  assign bus.m0_hsize = a_size[0]; assign bus.m1_hsize = a_size[1];
  assign bus.m0_hburst = a_burst[0]; assign bus.m1_hburst = a_burst[1];
  assign bus.m0_hprot = a_prot[0]; assign bus.m1_hprot = a_prot[1];
  assign bus.m0_hwrite = a_wr[0];  assign bus.m1_hwrite = a_wr[1];
  assign bus.m0_hwdata = a_wdata[0]; assign bus.m1_hwdata = a_wdata[1];
  assign bus.hready = s_ready;
  assign bus.hresp  = s_resp;
  assign bus.hrdata = s_rdata;

  // Reference model: owner index (-1 = nobody), previous owner, tenure-used flag, data-phase owner.
  int own, last, down;
  bit used, dvld;

  // Master agents: current job (beats, next beat, base), queued jobs, tenure bookkeeping.
  int          nb[2], bt[2], jobs[2], job_nb[2];
  logic [31:0] ba[2], db[2], job_ad[2], job_db[2], wd[2];
  logic        wr[2], job_wr[2];
  bit          did[2], want[2];
  bit          rnd;

  logic [EW-1:0] exp_q[$];
  int n_chk, n_pass;

  function automatic logic [EW-1:0] pk(
    input logic g0, input logic g1, input logic sel, input logic [31:0] ad, input logic [1:0] tr,
    input logic [2:0] sz, input logic [2:0] bu, input logic [3:0] pr, input logic w,
    input logic [31:0] wdat, input logic r0, input logic r1, input logic [31:0] rd0,
    input logic [31:0] rd1, input logic rdy0, input logic rdy1);
    return {g0, g1, sel, ad, tr, sz, bu, pr, w, wdat, r0, r1, rd0, rd1, rdy0, rdy1};
  endfunction

  always @(negedge hclk) begin
    if (exp_q.size() > 0) begin
      logic [EW-1:0] e, a;
      e = exp_q.pop_front();
      a = pk(bus.m0_gnt, bus.m1_gnt, bus.hsel, bus.haddr, bus.htrans, bus.hsize, bus.hburst,
             bus.hprot, bus.hwrite, bus.hwdata, bus.m0_hresp, bus.m1_hresp, bus.m0_hrdata,
             bus.m1_hrdata, bus.m0_hready, bus.m1_hready);
      n_chk++;
      if (a === e) n_pass++;
      else $display("FAIL outputs t=%0t got %h exp %h", $time, a, e);
    end
  end

  task automatic model_reset();
    own = -1; last = 1; used = 0; dvld = 0; down = 0;
    for (int n = 0; n < 2; n++) begin
      nb[n] = 0; bt[n] = 0; did[n] = 0; wd[n] = 32'h0;
    end
  endtask

  task automatic model_expect();
    logic [31:0] ea = 32'h0;
    logic [1:0]  et = 2'b00;
    logic [2:0]  es = 3'b000, eb = 3'b000;
    logic [3:0]  ep = 4'b0000;
    logic        ew = 1'b0;
    logic [31:0] ed;
    if (own >= 0) begin
      ea = a_addr[own]; et = a_trans[own]; es = a_size[own];
      eb = a_burst[own]; ep = a_prot[own]; ew = a_wr[own];
    end
    ed = dvld ? a_wdata[down] : 32'h0;
    exp_q.push_back(pk(own == 0, own == 1, own >= 0, ea, et, es, eb, ep, ew, ed,
                       s_resp && dvld && down == 0, s_resp && dvld && down == 1,
                       s_rdata, s_rdata, s_ready, s_ready));
  endtask

  // Arbitration rules applied at an edge, using the inputs that were on the bus before it.
  task automatic model_edge();
    int nw;
    logic [1:0] ht;
    logic rq;
    if (!s_ready) return;
    ht = (own >= 0) ? a_trans[own] : 2'b00;
    rq = (own >= 0) ? a_req[own] : 1'b0;
    if (own < 0) begin
      if (a_req[0] && a_req[1]) nw = 1 - last;
      else if (a_req[0])        nw = 0;
      else if (a_req[1])        nw = 1;
      else                      nw = -1;
    end else if (ht == 2'b00 && (used || !rq)) begin
      if (a_req[1-own]) nw = 1 - own;
      else if (rq)      nw = own;
      else              nw = -1;
    end else begin
      nw = own;
    end
    if (ht[1]) begin dvld = 1; down = own; end
    else dvld = 0;
    if (nw != own) used = 0;
    else if (ht == 2'b10) used = 1;
    if (nw >= 0) last = nw;
    own = nw;
  endtask

  task automatic agent_drive(input int n);
    a_req[n] = want[n];
    if (own == n && nb[n] == 0 && !did[n] && jobs[n] > 0) begin
      nb[n] = job_nb[n]; bt[n] = 0; ba[n] = job_ad[n]; wr[n] = job_wr[n]; db[n] = job_db[n];
    end
    if (own == n && nb[n] > 0) begin
      a_trans[n] = (bt[n] == 0) ? 2'b10 : 2'b11;
      a_addr[n]  = ba[n] + 32'(4 * bt[n]);
      a_size[n]  = 3'b010;
      a_burst[n] = (nb[n] == 4) ? 3'b011 : 3'b000;
      a_prot[n]  = 4'b0011;
      a_wr[n]    = wr[n];
    end else begin
      a_trans[n] = (own == n) ? 2'b00 : 2'($urandom_range(0, 3));
      a_addr[n]  = $urandom;
      a_size[n]  = 3'($urandom_range(0, 7));
      a_burst[n] = 3'($urandom_range(0, 7));
      a_prot[n]  = 4'($urandom_range(0, 15));
      a_wr[n]    = 1'($urandom_range(0, 1));
    end
    a_wdata[n] = wd[n];
  endtask

  task automatic agent_edge();
    for (int n = 0; n < 2; n++) begin
      if (s_ready && own == n && nb[n] > 0) begin
        wd[n] = db[n] + 32'(bt[n]);
        bt[n]++;
        if (bt[n] == nb[n]) begin
          nb[n] = 0; did[n] = 1; jobs[n]--; job_ad[n] += 32'h10;
          if (jobs[n] == 0) want[n] = 0;
        end
      end
    end
  endtask

  task automatic tick();
    if (!hresetn) model_reset();
    s_rdata = $urandom;
    for (int n = 0; n < 2; n++) begin
      if (rnd) begin
        a_req[n]   = ($urandom_range(0, 3) != 0);
        a_trans[n] = 2'($urandom_range(0, 3));
        a_addr[n]  = $urandom;
        a_size[n]  = 3'($urandom_range(0, 7));
        a_burst[n] = 3'($urandom_range(0, 7));
        a_prot[n]  = 4'($urandom_range(0, 15));
        a_wr[n]    = 1'($urandom_range(0, 1));
        a_wdata[n] = $urandom;
      end else begin
        agent_drive(n);
      end
    end
    model_expect();
    @(posedge hclk);
    if (hresetn) begin
      if (!rnd) agent_edge();
      model_edge();
    end
    for (int n = 0; n < 2; n++) if (own != n) did[n] = 0;
    #1;
  endtask

  task automatic run(input int cycles);
    repeat (cycles) tick();
  endtask

  task automatic set_job(input int n, input int beats, input logic [31:0] ad, input logic w,
                         input logic [31:0] d0, input int count);
    job_nb[n] = beats; job_ad[n] = ad; job_wr[n] = w; job_db[n] = d0; jobs[n] = count;
  endtask

  task automatic quiesce();
    want[0] = 0; want[1] = 0; jobs[0] = 0; jobs[1] = 0;
    s_ready = 1; s_resp = 0;
    run(6);
  endtask

  task automatic check_cond(input bit ok, input string name);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s got not-reached exp reached", name);
  endtask

  initial begin
    int errst, stall;
    bit stalled;
    n_chk = 0; n_pass = 0; rnd = 0;
    hresetn = 1'b0; s_ready = 1'b1; s_resp = 1'b0; s_rdata = 32'h0;
    for (int n = 0; n < 2; n++) begin
      a_req[n] = 0; a_addr[n] = 0; a_trans[n] = 0; a_size[n] = 0; a_burst[n] = 0;
      a_prot[n] = 0; a_wr[n] = 0; a_wdata[n] = 0; want[n] = 0; jobs[n] = 0;
      job_nb[n] = 0; job_ad[n] = 0; job_db[n] = 0; job_wr[n] = 0; ba[n] = 0; db[n] = 0; wr[n] = 0;
    end
    model_reset();
    @(posedge hclk); #1;

    // Reset held with both requesting, then release: m0 wins the first tie.
    want[0] = 1; want[1] = 1;
    run(3);
    hresetn = 1'b1;
    run(4);
    quiesce();

    // m0 alone: INCR4 write at 0x1000, data 0xA0..0xA3.
    set_job(0, 4, 32'h1000, 1'b1, 32'hA0, 1); want[0] = 1;
    run(10);
    quiesce();

    // Both requesting single reads: ownership alternates, one transfer per tenure.
    set_job(0, 1, 32'h0100, 1'b0, 32'h0, 4); set_job(1, 1, 32'h0800, 1'b0, 32'h0, 4);
    want[0] = 1; want[1] = 1;
    run(40);
    quiesce();

    // m0 INCR4 read with a two-cycle wait at beat 2 while m1 requests.
    set_job(0, 4, 32'h1100, 1'b0, 32'h0, 1); want[0] = 1;
    run(2);
    set_job(1, 1, 32'h1200, 1'b0, 32'h0, 1); want[1] = 1;
    stall = 0; stalled = 0;
    for (int i = 0; i < 20; i++) begin
      if (!stalled && own == 0 && nb[0] == 4 && bt[0] == 1) begin stall = 2; stalled = 1; end
      s_ready = (stall == 0);
      if (stall > 0) stall--;
      tick();
    end
    check_cond(stalled, "stall_at_beat2");
    quiesce();

    // m1 write at 0x2000 receives a two-cycle ERROR response while m0 is waiting.
    set_job(1, 1, 32'h2000, 1'b1, 32'h5A, 1); want[1] = 1;
    run(2);
    set_job(0, 1, 32'h3000, 1'b0, 32'h0, 1); want[0] = 1;
    errst = 0;
    for (int i = 0; i < 15; i++) begin
      s_ready = 1; s_resp = 0;
      if (errst == 0 && dvld && down == 1) begin s_ready = 0; s_resp = 1; errst = 1; end
      else if (errst == 1) begin s_resp = 1; errst = 2; end
      tick();
    end
    check_cond(errst == 2, "error_response_seen");
    quiesce();

    // Reset pulsed during m1's INCR4 beat 3; afterwards both request and m0 goes first.
    set_job(1, 4, 32'h4000, 1'b1, 32'hC0, 1); want[1] = 1;
    for (int i = 0; i < 20 && !(own == 1 && nb[1] == 4 && bt[1] == 2); i++) tick();
    check_cond(own == 1 && nb[1] == 4 && bt[1] == 2, "reached_beat3");
    hresetn = 1'b0;
    want[0] = 1; want[1] = 1;
    set_job(0, 1, 32'h5000, 1'b0, 32'h0, 1); set_job(1, 1, 32'h6000, 1'b0, 32'h0, 1);
    tick();
    hresetn = 1'b1;
    run(12);
    quiesce();

    // Random traffic, including wait states, errors and occasional resets.
    rnd = 1;
    for (int i = 0; i < 800; i++) begin
      hresetn = ($urandom_range(0, 149) != 0);
      s_ready = ($urandom_range(0, 3) != 0);
      s_resp  = ($urandom_range(0, 7) == 0);
      tick();
    end
    rnd = 0; hresetn = 1'b1;
    quiesce();

    @(negedge hclk); #1;
    check_cond(exp_q.size() == 0, "queue_drained");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
